pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined add/subtract unit; next generation of the team's fixed-width ripple adder.
//  WIDTH-bit operands are split into LANE-bit chunks, one chunk per pipeline stage; carry is registered between stages.
//  Valid/ready handshakes on both sides, so it drops into the datapath between operand mux and result regfile.
//  Adds subtract mode, signed-overflow and zero flags, and backpressure.
// PARAMETERS
//  WIDTH   20  operand/result width in bits; must be a multiple of LANE
//  LANE    5   bits resolved per stage (ripple chunk width)
//  STAGES  WIDTH/LANE  derived localparam, not overridable; equals pipeline latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands present this cycle
//  in_ready   out  1      unit accepts operands this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: A+B+Cin ; 1: A-B-Cin
//  out_valid  out  1      result present
//  out_ready  in   1      consumer takes result this cycle
//  Adder      out  WIDTH  result
//  Cout       out  1      raw carry out of MSB (sub: 1 = no borrow)
//  Ovf        out  1      two's-complement signed overflow
//  Zero       out  1      Adder == 0
// BEHAVIOUR
//  Reset: async on rst_n low; all valid bits, carries, data regs, Adder, Cout, Ovf, Zero clear to 0 immediately.
//    in_ready is 1 once rst_n is high.
//  Transfer: input on in_valid&&in_ready; output on out_valid&&out_ready.
//  Advance: adv = !out_valid || out_ready. Every stage register (data + valid) loads only when adv=1.
//    in_ready = adv (combinational).
//  Stall: adv=0 freezes every stage, including bubbles; pipeline holds contents and outputs stay stable.
//  Operand prep at entry: Bx = sub ? ~B : B; c0 = sub ? ~Cin : Cin.
//    Effective op is A + Bx + c0, so sub gives A - B - Cin.
//  Stage k (0..STAGES-1): adds chunk k of A/Bx with the carry from stage k-1 (c0 for k=0); registers LANE sum bits and carry.
//    Upper chunks of A/Bx travel in skew registers.
//    Lower result chunks travel in deskew registers, so all chunks of one op emerge together.
//  Latency: exactly STAGES cycles accept->out_valid when unstalled; throughput one op/cycle.
//  Flags, all registered with the final stage:
//    Cout = carry out of the last chunk.
//    Ovf = carry into MSB XOR carry out of MSB; needs the stage-final MSB carry-in from the lane adder.
//    Zero = ~|Adder.
//  Wrap-around: results modulo 2^WIDTH; no saturation.
//  Simultaneous in/out handshake while full: allowed; both complete in the same cycle.
//  in_valid=0 with adv=1: a bubble (valid=0) enters; data regs may load don't-care values, but flags/data are only meaningful with out_valid.
//  Reset mid-operation: all in-flight ops are discarded; no partial result is ever presented.
//  Operand/sub/Cin changes while in_valid&&!in_ready: ignored; the sampled value is the one present at transfer.
// STRUCTURE
//  Shared package/header addsub_defs: OP_ADD=1'b0, OP_SUB=1'b1; default WIDTH/LANE constants.
//    Also holds an elaboration check: WIDTH % LANE == 0.
//  Sub-module lane_adder #(LANE): combinational LANE-bit ripple built from onebit_adder cells.
//    Outputs sum, carry out and MSB carry-in (for Ovf).
//  Top instantiates STAGES lane_adder in a generate loop, plus the valid chain, skew/deskew regs and flag logic.
// TESTING (WIDTH=20, LANE=5, STAGES=4, out_ready=1 unless stated)
//  1 add A=0xFFFFF B=0x00001 Cin=0 -> 4 cycles later Adder=0x00000 Cout=1 Zero=1 Ovf=0.
//  2 add A=0x7FFFF B=0x00001 Cin=0 -> Adder=0x80000 Cout=0 Ovf=1 Zero=0.
//    add A=0 B=0 Cin=1 -> Adder=0x00001.
//  3 sub A=5 B=7 Cin=0 -> Adder=0xFFFFE Cout=0 Ovf=0.
//    sub A=0x80000 B=1 Cin=0 -> Adder=0x7FFFF Ovf=1 Cout=1.
//    sub A=9 B=4 Cin=1 -> Adder=4 Cout=1.
//  4 stream 200 random ops back-to-back, out_ready random 50%.
//    -> results in order and match the reference model; no drop/dup.
//    -> in_ready==(!out_valid||out_ready) every cycle; outputs stable while stalled.
//  5 hold out_ready=0 with 4 ops in flight for 10 cycles -> in_ready=0, Adder/flags frozen.
//    Then release -> 4 results drain on consecutive cycles.
//  6 assert rst_n=0 asynchronously mid-stream (between clock edges).
//    -> out_valid and all flags drop immediately.
//    -> after release, first new op appears exactly 4 cycles after acceptance; no stale result.

Source files
------------

// File: rtl/addsub_defs_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcode encoding,
// default geometry and the lane-split legality check used at elaboration.
package addsub_defs_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 20;
    localparam int DEF_LANE  = 5;

    // Operands must split into a whole number of non-empty lanes.
    function automatic bit lane_split_ok(input int width, input int lane);
        return (lane > 0) && (width >= lane) && ((width % lane) == 0);
    endfunction

endpackage

// File: rtl/lane_adder.sv
// Combinational LANE-bit ripple adder built from onebit_adder cells.
// Also exposes the carry into its MSB so the caller can form signed overflow.
module lane_adder #(
    parameter int LANE = 5
) (
    input  logic [LANE-1:0] a_i,
    input  logic [LANE-1:0] b_i,
    input  logic            cin_i,
    output logic [LANE-1:0] sum_o,
    output logic            cout_o,
    output logic            cmsb_o
);

    logic [LANE:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < LANE; i++) begin : g_bit
        onebit_adder u_bit (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_o = carry[LANE];
    assign cmsb_o = carry[LANE-1];

endmodule

// File: rtl/onebit_adder.sv
// Single-bit full adder cell; the ripple element of lane_adder.
module onebit_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one LANE-bit ripple chunk per stage, carry
// registered between stages, valid/ready on both sides with a global advance.
module pipelined_addsub
    import addsub_defs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANE  = DEF_LANE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Adder,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int STAGES = WIDTH / LANE;
    localparam logic [WIDTH-1:0] LANE_MASK = WIDTH'({LANE{1'b1}});

    if (!lane_split_ok(WIDTH, LANE)) begin : g_bad_split
        $error("pipelined_addsub: WIDTH must be a positive multiple of LANE");
    end

    logic             adv;

    // Inputs presented to each stage's lane adder (stage 0 from the ports).
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_r   [STAGES];
    logic             st_c   [STAGES];
    logic             st_v   [STAGES];

    logic [LANE-1:0]  sum_d  [STAGES];
    logic             cout_d [STAGES];
    logic             cmsb_d [STAGES];
    logic [WIDTH-1:0] res_d  [STAGES];

    // a_q/b_q are the operand skew chain, r_q the result deskew chain.
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] r_q     [STAGES];
    logic             carry_q [STAGES];
    logic             vld_q   [STAGES];
    logic             ovf_q;
    logic             zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_entry
            assign st_a[k] = A;
            assign st_b[k] = (sub == OP_SUB) ? ~B : B;
            assign st_c[k] = (sub == OP_ADD) ? Cin : ~Cin;
            assign st_r[k] = '0;
            assign st_v[k] = in_valid;
        end else begin : g_chain
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_c[k] = carry_q[k-1];
            assign st_r[k] = r_q[k-1];
            assign st_v[k] = vld_q[k-1];
        end

        lane_adder #(.LANE(LANE)) u_lane (
            .a_i    (st_a[k][k*LANE +: LANE]),
            .b_i    (st_b[k][k*LANE +: LANE]),
            .cin_i  (st_c[k]),
            .sum_o  (sum_d[k]),
            .cout_o (cout_d[k]),
            .cmsb_o (cmsb_d[k])
        );

        assign res_d[k] = (st_r[k] & ~(LANE_MASK << (k*LANE)))
                        | (WIDTH'(sum_d[k]) << (k*LANE));
    end

    // A full output slot blocks everything upstream, bubbles included.
    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                r_q[k]     <= '0;
                carry_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]   <= st_v[k];
                a_q[k]     <= st_a[k];
                b_q[k]     <= st_b[k];
                r_q[k]     <= res_d[k];
                carry_q[k] <= cout_d[k];
            end
            ovf_q  <= cout_d[STAGES-1] ^ cmsb_d[STAGES-1];
            zero_q <= ~|res_d[STAGES-1];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign Adder     = r_q[STAGES-1];
    assign Cout      = carry_q[STAGES-1];
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=20, LANE=5): directed corner
// cases, a random backpressured stream, a full stall and an async reset.
module tb_pipelined_addsub;
    import addsub_defs_pkg::*;

    localparam int W      = 20;
    localparam int L      = 5;
    localparam int STAGES = W / L;

    logic         clk, rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, Adder;
    logic         Cin, sub, Cout, Ovf, Zero;

    typedef struct {
        logic [W-1:0] adder;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t q[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_out = 0;
    bit   lat_on   = 0;
    bit   rand_rdy = 0;
    bit   prev_stall = 0;
    logic [W-1:0] prev_adder;
    logic prev_cout, prev_ovf, prev_zero;

    pipelined_addsub #(.WIDTH(W), .LANE(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Adder     (Adder),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Whole-word reference: A + (sub ? ~B : B) + (sub ? ~Cin : Cin) at W+1 bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic s);
        exp_t         e;
        logic [W-1:0] bx;
        logic         c0;
        logic [W:0]   full;
        bx   = s ? ~b : b;
        c0   = s ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c0};
        e.adder = full[W-1:0];
        e.cout  = full[W];
        e.ovf   = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        e.zero  = (full[W-1:0] == '0);
        e.cyc   = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] adder, input logic cout,
                                input logic ovf, input logic zero);
        exp_t e;
        e.adder = adder;
        e.cout  = cout;
        e.ovf   = ovf;
        e.zero  = zero;
        e.cyc   = 0;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the op.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic s, input exp_t e);
        A        = a;
        B        = b;
        Cin      = cin;
        sub      = s;
        in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t == 200) begin
                chk("accept_timeout", 32'(in_ready), 32'(1));
                in_valid = 1'b0;
                return;
            end
        end
        e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic s, input logic [W-1:0] r, input logic co,
                       input logic ov, input logic z);
        send(a, b, cin, s, mk(r, co, ov, z));
    endtask

    task automatic rnd_op();
        logic [W-1:0] a, b;
        logic         c, s;
        case ($urandom_range(0, 7))
            0:       a = '0;
            1:       a = '1;
            2:       a = 20'h7FFFF;
            3:       a = 20'h80000;
            default: a = W'($urandom);
        endcase
        b = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
        c = 1'($urandom_range(0, 1));
        s = 1'($urandom_range(0, 1));
        send(a, b, c, s, model(a, b, c, s));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                chk("hold_vld",  32'(out_valid), 32'(1));
                chk("hold_sum",  32'(Adder), 32'(prev_adder));
                chk("hold_cout", 32'(Cout),  32'(prev_cout));
                chk("hold_ovf",  32'(Ovf),   32'(prev_ovf));
                chk("hold_zero", 32'(Zero),  32'(prev_zero));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious", 32'(out_valid), 32'(0));
                end else begin
                    chk("adder", 32'(Adder), 32'(q[0].adder));
                    chk("cout",  32'(Cout),  32'(q[0].cout));
                    chk("ovf",   32'(Ovf),   32'(q[0].ovf));
                    chk("zero",  32'(Zero),  32'(q[0].zero));
                    if (lat_on) chk("latency", 32'(cyc - q[0].cyc), 32'(STAGES));
                    void'(q.pop_front());
                end
                n_out <= n_out + 1;
            end
            prev_stall <= out_valid && !out_ready;
            prev_adder <= Adder;
            prev_cout  <= Cout;
            prev_ovf   <= Ovf;
            prev_zero  <= Zero;
        end
    end

    int n0;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        sub       = OP_ADD;
        out_ready = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld",  32'(out_valid), 32'(0));
        chk("rst_sum",  32'(Adder), 32'(0));
        chk("rst_cout", 32'(Cout), 32'(0));
        chk("rst_ovf",  32'(Ovf), 32'(0));
        chk("rst_zero", 32'(Zero), 32'(0));
        #20 rst_n = 1'b1;
        #1 chk("rst_rdy", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        // Directed add/sub corners, unstalled, latency checked.
        lat_on = 1'b1;
        dir(20'hFFFFF, 20'h00001, 1'b0, OP_ADD, 20'h00000, 1'b1, 1'b0, 1'b1);
        dir(20'h7FFFF, 20'h00001, 1'b0, OP_ADD, 20'h80000, 1'b0, 1'b1, 1'b0);
        dir(20'h00000, 20'h00000, 1'b1, OP_ADD, 20'h00001, 1'b0, 1'b0, 1'b0);
        dir(20'h00005, 20'h00007, 1'b0, OP_SUB, 20'hFFFFE, 1'b0, 1'b0, 1'b0);
        dir(20'h80000, 20'h00001, 1'b0, OP_SUB, 20'h7FFFF, 1'b1, 1'b1, 1'b0);
        dir(20'h00009, 20'h00004, 1'b1, OP_SUB, 20'h00004, 1'b1, 1'b0, 1'b0);
        dir(20'h12345, 20'h12345, 1'b0, OP_SUB, 20'h00000, 1'b1, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1 chk("dir_drain", 32'(q.size()), 32'(0));

        // Random back-to-back stream with random backpressure.
        lat_on   = 1'b0;
        n0       = n_out;
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) rnd_op();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rnd_drain", 32'(q.size()), 32'(0));
        chk("rnd_count", 32'(n_out - n0), 32'(200));

        // Fill the pipe with out_ready low, hold, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            send(a, b, 1'(i & 1), 1'(i >> 1), model(a, b, 1'(i & 1), 1'(i >> 1)));
        end
        repeat (10) begin
            @(negedge clk);
            chk("stall_rdy", 32'(in_ready), 32'(0));
            chk("stall_vld", 32'(out_valid), 32'(1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_vld", 32'(out_valid), 32'(1));
        end
        @(negedge clk);
        chk("drain_end", 32'(out_valid), 32'(0));
        chk("stall_q", 32'(q.size()), 32'(0));

        // Async reset mid-stream, then one fresh op.
        @(posedge clk);
        #1;
        lat_on = 1'b1;
        for (int i = 0; i < 5; i++) rnd_op();
        chk("pre_rst_vld", 32'(out_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld",  32'(out_valid), 32'(0));
        chk("arst_sum",  32'(Adder), 32'(0));
        chk("arst_cout", 32'(Cout), 32'(0));
        chk("arst_ovf",  32'(Ovf), 32'(0));
        chk("arst_zero", 32'(Zero), 32'(0));
        q.delete();
        #13 rst_n = 1'b1;
        #1 chk("arst_rdy", 32'(in_ready), 32'(1));
        n0 = n_out;
        @(posedge clk);
        #1;
        send(20'h0ABCD, 20'h01234, 1'b1, OP_ADD, mk(20'h0BE02, 1'b0, 1'b0, 1'b0));
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_q",   32'(q.size()), 32'(0));
        chk("post_rst_cnt", 32'(n_out - n0), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
